// File: rtl/id_stage_pkg.sv
// Shared RV32I decode constants for the decode stage: opcodes, funct3
// codes, branch codes, NOP, ALU op codes, immediate selects and the
// packed state types used by id_stage.
package id_stage_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch codes seen by fetch; unsigned variants reuse BLT/BGE
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BEQ     = 3'd1;
    localparam logic [2:0] BNE     = 3'd2;
    localparam logic [2:0] BLT     = 3'd3;
    localparam logic [2:0] BGE     = 3'd4;

    localparam logic [31:0] NOP = 32'h00000013;

    // ALU op codes
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_LUI   = 4'd10;  // pass immediate
    localparam logic [3:0] ALU_AUIPC = 4'd11;  // pc + immediate
    localparam logic [3:0] ALU_LINK  = 4'd12;  // pc + 4

    // Drain length after FENCE/ECALL/EBREAK
    localparam logic [1:0] DRAIN_CYCLES = 2'd3;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_sel_e;

    typedef enum logic {
        ST_IDLE,
        ST_DRAIN
    } ctrl_state_e;

    // Control-hazard FSM state, kept together so it can be probed as one unit
    typedef struct packed {
        ctrl_state_e state;
        logic [1:0]  cnt;
    } ctrl_t;

    // One scoreboard slot: an in-flight register writer
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_slot_t;

    // Registered bundle handed to execute
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src_imm;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [2:0]  funct3;
    } ex_bundle_t;

    // Sign-extended immediate; opcode bits are never part of an immediate
    function automatic logic [31:0] imm_gen(input logic [31:7] ins, input imm_sel_e sel);
        logic [31:0] imm;
        imm = '0;
        case (sel)
            IMM_I: imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B: imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U: imm = {ins[31:12], 12'b0};
            IMM_J: imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // ALU op for OP / OP-IMM; bit 30 selects SUB (register form only) and SRA
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt,
                                              input logic is_imm);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            F3_ADD:  op = (alt && !is_imm) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // True when a used source register is produced by the slot's writer
    function automatic logic sb_hit(input sb_slot_t slot, input logic [4:0] rs,
                                    input logic used);
        return slot.valid && used && (rs != 5'd0) && (slot.rd == rs);
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two asynchronous read ports, one write port taken
// on the rising edge, x0 hardwired to zero. With REGFILE_WRITE_BYPASS_EN
// defined, a write in the same cycle is forwarded onto a matching read.
module id_stage_regfile (
    input  logic        Clk,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Next register contents: only the addressed non-zero entry changes
    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != 5'd0)) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge Clk) begin
        regs_q <= regs_d;
    end

    // Asynchronous reads, x0 forced to zero, optional write forwarding
    always_comb begin
        rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
        rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (we_i && (waddr_i != 5'd0) && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
        if (we_i && (waddr_i != 5'd0) && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
`endif
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register read, immediate build, jump/branch target
// resolution, data/control hazard stalls and the registered EX bundle.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN (forward write-back to
// the read ports and stop treating the WB scoreboard slot as a hazard).
module id_stage
    import id_stage_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instruction_i,
    input  logic [31:0] Pc_i,
    input  logic        Wb_en_i,
    input  logic [4:0]  Wb_rd_i,
    input  logic [31:0] Wb_data_i,
    output logic        Inst_jump,
    output logic [2:0]  Inst_branch,
    output logic [31:0] Src_jump_target_o,
    output logic [31:0] Src_branch_target_o,
    output logic        Src_branch_equal_o,
    output logic        Src_branch_less_o,
    output logic        Stall_data_hazard,
    output logic        Stall_ctrl_hazard,
    output logic        Ex_valid,
    output logic [31:0] Ex_pc,
    output logic [31:0] Ex_rs1_data,
    output logic [31:0] Ex_rs2_data,
    output logic [31:0] Ex_imm,
    output logic [4:0]  Ex_rs1,
    output logic [4:0]  Ex_rs2,
    output logic [4:0]  Ex_rd,
    output logic [3:0]  Ex_alu_op,
    output logic        Ex_alu_src_imm,
    output logic        Ex_mem_read,
    output logic        Ex_mem_write,
    output logic        Ex_reg_write,
    output logic [2:0]  Ex_funct3,
    output logic [7:0]  ID_tracker
);

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, imm;

    imm_sel_e    imm_sel;
    logic [3:0]  alu_op;
    logic        alu_src_imm, mem_read, mem_write, writes_rd, reg_write;
    logic        use_rs1, use_rs2, is_jal, is_jalr, is_sys, br_unsigned;
    logic [2:0]  br_code;

    logic        accept, load_use, branch_hazard, wb_hazard, stall_data;
    logic        issue, stall_ctrl;
    logic [31:0] jalr_sum;

    ex_bundle_t  ex_d, ex_q;
    sb_slot_t    sb_ex_d, sb_ex_q, sb_mem_q, sb_wb_q;
    ctrl_t       ctrl_d, ctrl_q;
    logic [7:0]  tracker_d, tracker_q;

    // Anything outside RV32I is replaced by NOP before decode
    always_comb begin
        inst = NOP;
        case (Instruction_i[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM:
                inst = Instruction_i;
            default: inst = NOP;
        endcase
    end

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    id_stage_regfile u_regfile (
        .Clk      (Clk),
        .we_i     (Wb_en_i),
        .waddr_i  (Wb_rd_i),
        .wdata_i  (Wb_data_i),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data)
    );

    // Opcode decode into controls, operand usage and branch code
    always_comb begin
        imm_sel     = IMM_NONE;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        writes_rd   = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        is_sys      = 1'b0;
        br_code     = BR_NONE;
        br_unsigned = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm_sel = IMM_U; alu_op = ALU_LUI; alu_src_imm = 1'b1; writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                imm_sel = IMM_U; alu_op = ALU_AUIPC; alu_src_imm = 1'b1; writes_rd = 1'b1;
            end
            OPC_JAL: begin
                imm_sel = IMM_J; alu_op = ALU_LINK; writes_rd = 1'b1; is_jal = 1'b1;
            end
            OPC_JALR: begin
                imm_sel = IMM_I; alu_op = ALU_LINK; writes_rd = 1'b1; use_rs1 = 1'b1;
                is_jalr = 1'b1;
            end
            OPC_BRANCH: begin
                imm_sel = IMM_B; alu_op = ALU_SUB; use_rs1 = 1'b1; use_rs2 = 1'b1;
                br_unsigned = funct3[1];
                case (funct3)
                    F3_BEQ:           br_code = BEQ;
                    F3_BNE:           br_code = BNE;
                    F3_BLT, F3_BLTU:  br_code = BLT;
                    F3_BGE, F3_BGEU:  br_code = BGE;
                    default:          br_code = BR_NONE;
                endcase
            end
            OPC_LOAD: begin
                imm_sel = IMM_I; alu_src_imm = 1'b1; mem_read = 1'b1; writes_rd = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                imm_sel = IMM_S; alu_src_imm = 1'b1; mem_write = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                imm_sel = IMM_I; alu_src_imm = 1'b1; writes_rd = 1'b1; use_rs1 = 1'b1;
                alu_op = alu_decode(funct3, inst[30], 1'b1);
            end
            OPC_OP: begin
                writes_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                alu_op = alu_decode(funct3, inst[30], 1'b0);
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                is_sys = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm       = imm_gen(inst[31:7], imm_sel);
    assign reg_write = writes_rd && (rd != 5'd0);

    // Redirect targets and comparator results
    assign jalr_sum            = rs1_data + imm;
    assign Src_jump_target_o   = is_jal ? (Pc_i + imm) : {jalr_sum[31:1], 1'b0};
    assign Src_branch_target_o = Pc_i + imm;
    assign Src_branch_equal_o  = (rs1_data == rs2_data);
    assign Src_branch_less_o   = br_unsigned ? (rs1_data < rs2_data)
                                             : ($signed(rs1_data) < $signed(rs2_data));

    // Decode is live in IDLE and on the final DRAIN cycle; otherwise the
    // fetch-injected filler is ignored.
    assign accept = (ctrl_q.state == ST_IDLE) || (ctrl_q.cnt == 2'd0);

    assign load_use = sb_ex_q.is_load &&
                      (sb_hit(sb_ex_q, rs1, use_rs1) || sb_hit(sb_ex_q, rs2, use_rs2));
    assign branch_hazard = ((br_code != BR_NONE) || is_jalr) &&
                           (sb_hit(sb_ex_q, rs1, use_rs1) || sb_hit(sb_ex_q, rs2, use_rs2) ||
                            sb_hit(sb_mem_q, rs1, use_rs1) || sb_hit(sb_mem_q, rs2, use_rs2));
`ifdef REGFILE_WRITE_BYPASS_EN
    assign wb_hazard = 1'b0;
`else
    // A write-back value only becomes readable the cycle after it is written
    assign wb_hazard = sb_hit(sb_wb_q, rs1, use_rs1) || sb_hit(sb_wb_q, rs2, use_rs2);
`endif

    assign stall_data = accept && (load_use || branch_hazard || wb_hazard);
    assign issue      = accept && !stall_data;

    assign Stall_data_hazard = stall_data;
    assign Stall_ctrl_hazard = stall_ctrl;
    assign Inst_jump         = issue && (is_jal || is_jalr);
    assign Inst_branch       = issue ? br_code : BR_NONE;

    // Control-hazard FSM: FENCE/ECALL/EBREAK issue once then drain fetch
    always_comb begin
        ctrl_d     = ctrl_q;
        stall_ctrl = 1'b0;
        case (ctrl_q.state)
            ST_IDLE: begin
                if (is_sys && !stall_data) begin
                    stall_ctrl   = 1'b1;
                    ctrl_d.state = ST_DRAIN;
                    ctrl_d.cnt   = DRAIN_CYCLES;
                end
            end
            ST_DRAIN: begin
                if (ctrl_q.cnt != 2'd0) begin
                    stall_ctrl = 1'b1;
                    ctrl_d.cnt = ctrl_q.cnt - 2'd1;
                end else if (is_sys && !stall_data) begin
                    stall_ctrl = 1'b1;
                    ctrl_d.cnt = DRAIN_CYCLES;
                end else begin
                    ctrl_d.state = ST_IDLE;
                end
            end
            default: ctrl_d.state = ST_IDLE;
        endcase
    end

    // EX bundle, scoreboard entry and issue counter for the next cycle
    always_comb begin
        ex_d      = '0;
        sb_ex_d   = '0;
        tracker_d = tracker_q;
        if (issue) begin
            ex_d.valid       = 1'b1;
            ex_d.pc          = Pc_i;
            ex_d.rs1_data    = rs1_data;
            ex_d.rs2_data    = rs2_data;
            ex_d.imm         = imm;
            ex_d.rs1         = rs1;
            ex_d.rs2         = rs2;
            ex_d.rd          = rd;
            ex_d.alu_op      = alu_op;
            ex_d.alu_src_imm = alu_src_imm;
            ex_d.mem_read    = mem_read;
            ex_d.mem_write   = mem_write;
            ex_d.reg_write   = reg_write;
            ex_d.funct3      = funct3;
            sb_ex_d.valid    = reg_write;
            sb_ex_d.rd       = reg_write ? rd : 5'd0;
            sb_ex_d.is_load  = reg_write && mem_read;
            tracker_d        = tracker_q + 8'd1;
        end
    end

    // State registers; the scoreboard shifts every cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_q      <= '0;
            sb_ex_q   <= '0;
            sb_mem_q  <= '0;
            sb_wb_q   <= '0;
            ctrl_q    <= '{state: ST_IDLE, cnt: 2'd0};
            tracker_q <= '0;
        end else begin
            ex_q      <= ex_d;
            sb_ex_q   <= sb_ex_d;
            sb_mem_q  <= sb_ex_q;
            sb_wb_q   <= sb_mem_q;
            ctrl_q    <= ctrl_d;
            tracker_q <= tracker_d;
        end
    end

    assign Ex_valid       = ex_q.valid;
    assign Ex_pc          = ex_q.pc;
    assign Ex_rs1_data    = ex_q.rs1_data;
    assign Ex_rs2_data    = ex_q.rs2_data;
    assign Ex_imm         = ex_q.imm;
    assign Ex_rs1         = ex_q.rs1;
    assign Ex_rs2         = ex_q.rs2;
    assign Ex_rd          = ex_q.rd;
    assign Ex_alu_op      = ex_q.alu_op;
    assign Ex_alu_src_imm = ex_q.alu_src_imm;
    assign Ex_mem_read    = ex_q.mem_read;
    assign Ex_mem_write   = ex_q.mem_write;
    assign Ex_reg_write   = ex_q.reg_write;
    assign Ex_funct3      = ex_q.funct3;
    assign ID_tracker     = tracker_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset state, issue, load-use, branches,
// jump targets, x0 handling, unknown opcodes and the FENCE drain.
module tb_id_stage;

  localparam logic [31:0] NOP_I = 32'h00000013;

  logic        Clk;
  logic        Reset;
  logic [31:0] Instruction_i;
  logic [31:0] Pc_i;
  logic        Wb_en_i;
  logic [4:0]  Wb_rd_i;
  logic [31:0] Wb_data_i;
  logic        Inst_jump;
  logic [2:0]  Inst_branch;
  logic [31:0] Src_jump_target_o;
  logic [31:0] Src_branch_target_o;
  logic        Src_branch_equal_o;
  logic        Src_branch_less_o;
  logic        Stall_data_hazard;
  logic        Stall_ctrl_hazard;
  logic        Ex_valid;
  logic [31:0] Ex_pc;
  logic [31:0] Ex_rs1_data;
  logic [31:0] Ex_rs2_data;
  logic [31:0] Ex_imm;
  logic [4:0]  Ex_rs1;
  logic [4:0]  Ex_rs2;
  logic [4:0]  Ex_rd;
  logic [3:0]  Ex_alu_op;
  logic        Ex_alu_src_imm;
  logic        Ex_mem_read;
  logic        Ex_mem_write;
  logic        Ex_reg_write;
  logic [2:0]  Ex_funct3;
  logic [7:0]  ID_tracker;

  int errors = 0;
  int checks = 0;
  int stall_cycles;
  int ctrl_cycles;
  int issues;
  int exp_stalls;

  id_stage dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .Instruction_i       (Instruction_i),
    .Pc_i                (Pc_i),
    .Wb_en_i             (Wb_en_i),
    .Wb_rd_i             (Wb_rd_i),
    .Wb_data_i           (Wb_data_i),
    .Inst_jump           (Inst_jump),
    .Inst_branch         (Inst_branch),
    .Src_jump_target_o   (Src_jump_target_o),
    .Src_branch_target_o (Src_branch_target_o),
    .Src_branch_equal_o  (Src_branch_equal_o),
    .Src_branch_less_o   (Src_branch_less_o),
    .Stall_data_hazard   (Stall_data_hazard),
    .Stall_ctrl_hazard   (Stall_ctrl_hazard),
    .Ex_valid            (Ex_valid),
    .Ex_pc               (Ex_pc),
    .Ex_rs1_data         (Ex_rs1_data),
    .Ex_rs2_data         (Ex_rs2_data),
    .Ex_imm              (Ex_imm),
    .Ex_rs1              (Ex_rs1),
    .Ex_rs2              (Ex_rs2),
    .Ex_rd               (Ex_rd),
    .Ex_alu_op           (Ex_alu_op),
    .Ex_alu_src_imm      (Ex_alu_src_imm),
    .Ex_mem_read         (Ex_mem_read),
    .Ex_mem_write        (Ex_mem_write),
    .Ex_reg_write        (Ex_reg_write),
    .Ex_funct3           (Ex_funct3),
    .ID_tracker          (ID_tracker)
  );

  // Clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Write-back port drive for one cycle
  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    Wb_en_i   = 1'b1;
    Wb_rd_i   = r;
    Wb_data_i = d;
    tick();
    Wb_en_i   = 1'b0;
  endtask

  // Empty the scoreboard with NOPs
  task automatic flush();
    Instruction_i = NOP_I;
    repeat (4) tick();
  endtask

  initial begin
    Reset         = 1'b1;
    Instruction_i = NOP_I;
    Pc_i          = 32'd0;
    Wb_en_i       = 1'b0;
    Wb_rd_i       = 5'd0;
    Wb_data_i     = 32'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_stalls = 2;
`else
    exp_stalls = 3;
`endif

    // Reset state
    repeat (2) tick();
    #1;
    check("rst_ex_valid", Ex_valid, 0);
    check("rst_tracker", ID_tracker, 0);
    check("rst_ex_imm", Ex_imm, 0);
    check("rst_ctrl_stall", Stall_ctrl_hazard, 0);

    // addi x1,x0,5 right out of reset
    Reset = 1'b0;
    Instruction_i = 32'h00500093;
    Pc_i = 32'h0;
    #1;
    check("addi_no_stall", Stall_data_hazard, 0);
    tick();
    Instruction_i = NOP_I;
    #1;
    check("addi_ex_valid", Ex_valid, 1);
    check("addi_ex_imm", Ex_imm, 5);
    check("addi_ex_rd", Ex_rd, 1);
    check("addi_reg_write", Ex_reg_write, 1);
    check("addi_src_imm", Ex_alu_src_imm, 1);
    check("addi_tracker", ID_tracker, 1);

    // lw x2,0(x1) then add x3,x2,x2: one bubble
    flush();
    Instruction_i = 32'h0000A103;
    Pc_i = 32'h4;
    #1;
    check("lw_no_stall", Stall_data_hazard, 0);
    tick();
    Instruction_i = 32'h002101B3;
    Pc_i = 32'h8;
    #1;
    check("lu_stall_c1", Stall_data_hazard, 1);
    check("lu_lw_issued", Ex_valid, 1);
    check("lu_lw_memread", Ex_mem_read, 1);
    check("lu_lw_funct3", Ex_funct3, 3'b010);
    tick();
    #1;
    check("lu_stall_c2", Stall_data_hazard, 0);
    check("lu_bubble_valid", Ex_valid, 0);
    check("lu_bubble_memread", Ex_mem_read, 0);
    tick();
    Instruction_i = NOP_I;
    #1;
    check("lu_add_valid", Ex_valid, 1);
    check("lu_add_rd", Ex_rd, 3);

    // beq/bne x5,x6 with x5=x6=7 at 0x40
    flush();
    wb_write(5'd5, 32'd7);
    wb_write(5'd6, 32'd7);
    Instruction_i = 32'h00628863;
    Pc_i = 32'h40;
    #1;
    check("beq_code", Inst_branch, 3'd1);
    check("beq_equal", Src_branch_equal_o, 1);
    check("beq_target", Src_branch_target_o, 32'h50);
    check("beq_no_stall", Stall_data_hazard, 0);
    Instruction_i = 32'h00629863;
    #1;
    check("bne_code", Inst_branch, 3'd2);

    // Signed vs unsigned less-than: x5=0xFFFFFFFF, x6=1
    Instruction_i = NOP_I;
    wb_write(5'd5, 32'hFFFFFFFF);
    wb_write(5'd6, 32'd1);
    Instruction_i = 32'h0062E863;
    #1;
    check("bltu_code", Inst_branch, 3'd3);
    check("bltu_less", Src_branch_less_o, 0);
    Instruction_i = 32'h0062C863;
    #1;
    check("blt_less", Src_branch_less_o, 1);
    Instruction_i = 32'h0062F863;
    #1;
    check("bgeu_code", Inst_branch, 3'd4);

    // addi x7,x0,0x103 then jalr x1,4(x7); x7 written back when addi is in WB
    flush();
    Instruction_i = 32'h10300393;
    Pc_i = 32'h80;
    tick();
    Instruction_i = 32'h004380E7;
    Pc_i = 32'h84;
    stall_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      Wb_en_i   = (i == 2);
      Wb_rd_i   = 5'd7;
      Wb_data_i = 32'h103;
      #1;
      if (!Stall_data_hazard) break;
      stall_cycles++;
      check("jalr_jump_masked", Inst_jump, 0);
      tick();
    end
    check("jalr_stall_cycles", stall_cycles, exp_stalls);
    check("jalr_target", Src_jump_target_o, 32'h106);
    check("jalr_jump", Inst_jump, 1);
    tick();
    Wb_en_i = 1'b0;

    // x0 ignores writes; JAL target
    flush();
    wb_write(5'd0, 32'h55);
    Instruction_i = 32'h000000E7;
    #1;
    check("x0_jalr_target", Src_jump_target_o, 32'h0);
    Instruction_i = 32'h008000EF;
    Pc_i = 32'h100;
    #1;
    check("jal_target", Src_jump_target_o, 32'h108);
    check("jal_jump", Inst_jump, 1);

    // addi x0 is never a hazard for a following beq x0,x0
    tick();
    Instruction_i = 32'h00100013;
    tick();
    Instruction_i = 32'h00000863;
    #1;
    check("x0_no_hazard", Stall_data_hazard, 0);

    // Unknown opcode decodes as NOP
    tick();
    Instruction_i = 32'hFFFFFFFF;
    #1;
    check("unk_no_jump", Inst_jump, 0);
    check("unk_no_branch", Inst_branch, 0);
    tick();
    Instruction_i = NOP_I;
    #1;
    check("unk_ex_valid", Ex_valid, 1);
    check("unk_ex_rd", Ex_rd, 0);
    check("unk_reg_write", Ex_reg_write, 0);
    check("unk_mem_write", Ex_mem_write, 0);
    check("unk_ex_imm", Ex_imm, 0);

    // FENCE: issued once, control stall for four cycles
    flush();
    Instruction_i = 32'h0FF0000F;
    ctrl_cycles = 0;
    issues = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (Stall_ctrl_hazard) ctrl_cycles++;
      if (i >= 1 && i <= 4 && Ex_valid) issues++;
      tick();
      Instruction_i = NOP_I;
    end
    check("fence_ctrl_cycles", ctrl_cycles, 4);
    check("fence_issues", issues, 1);

    // Reset in the middle of DRAIN
    flush();
    Instruction_i = 32'h0FF0000F;
    tick();
    Instruction_i = NOP_I;
    #1;
    check("drain_ctrl_high", Stall_ctrl_hazard, 1);
    tick();
    Reset = 1'b1;
    tick();
    #1;
    check("drain_rst_ctrl", Stall_ctrl_hazard, 0);
    check("drain_rst_data", Stall_data_hazard, 0);
    check("drain_rst_valid", Ex_valid, 0);
    check("drain_rst_tracker", ID_tracker, 0);
    Reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
